// File: rtl/mul_share_pkg.sv
`default_nettype none
// ============================================================================
// mul_share_pkg : shared types and helpers for the multiplier-sharing scheduler
// Revision      : 1.0
// ============================================================================
package mul_share_pkg;

  localparam int MAX_REQ   = 8;
  localparam int DEF_WIDTH = 8;
  localparam int CNT_W     = $clog2(DEF_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  // First set request after 'last', wrapping modulo n_req.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [2:0]         last,
                                         input int unsigned        n_req);
    logic [2:0]  pick;
    logic        found;
    int unsigned idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_REQ; i++) begin
      if (i <= n_req && !found) begin
        idx = (32'(last) + i) % n_req;
        if (req[idx]) begin
          pick  = idx[2:0];
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_shift_add.sv
`default_nettype none
// ============================================================================
// mul_shift_add : fixed-latency unsigned shift-add multiplier (WIDTH steps)
// Revision      : 1.0
// ============================================================================
module mul_shift_add
  import mul_share_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q,   acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q,   cnt_d;

  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (start) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = CW'(WIDTH);
    end else if (cnt_q != '0) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  // done marks the final step; the product is settled on the following cycle.
  assign busy    = (cnt_q != '0);
  assign done    = (cnt_q == CW'(1));
  assign product = acc_q;

endmodule
`default_nettype wire

// File: rtl/mul_share_sched.sv
`default_nettype none
// ============================================================================
// mul_share_sched : round-robin arbiter sharing one shift-add multiplier
// Revision        : 1.0
// ============================================================================
module mul_share_sched
  import mul_share_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int WIDTH = 8,
  parameter int IDW   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] opa,
  input  logic [N_REQ*WIDTH-1:0] opb,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic                   done,
  output logic [2*WIDTH-1:0]     res,
  output logic [IDW-1:0]         res_id
);

  state_e             state_q, state_d;
  logic [IDW-1:0]     last_q,  last_d;
  logic [2*WIDTH-1:0] res_q,   res_d;
  logic [IDW-1:0]     res_id_q, res_id_d;

  logic [MAX_REQ-1:0] req_pad;
  logic [IDW-1:0]     pick_idx;
  logic               mul_start;
  logic [WIDTH-1:0]   mul_a, mul_b;
  logic               mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_product;

  assign req_pad  = MAX_REQ'(req);
  assign pick_idx = IDW'(rr_pick(req_pad, 3'(last_q), N_REQ));
  assign mul_a    = opa[WIDTH*int'(pick_idx) +: WIDTH];
  assign mul_b    = opb[WIDTH*int'(pick_idx) +: WIDTH];

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    res_d     = res_q;
    res_id_d  = res_id_q;
    gnt       = '0;
    mul_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt[pick_idx] = 1'b1;
          mul_start     = 1'b1;
          last_d        = pick_idx;
          state_d       = MUL;
        end
      end
      MUL: begin
        if (mul_done) state_d = DONE;
      end
      DONE: begin
        res_d    = mul_product;
        res_id_d = last_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= IDW'(N_REQ - 1);
      res_q    <= '0;
      res_id_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      res_q    <= res_d;
      res_id_q <= res_id_d;
    end
  end

  // The DONE cycle bypasses the holding registers so res is valid with done.
  assign done   = (state_q == DONE);
  assign busy   = mul_busy || done;
  assign res    = done ? mul_product : res_q;
  assign res_id = done ? last_q : res_id_q;

  mul_shift_add #(
    .WIDTH (WIDTH),
    .CW    ($clog2(WIDTH + 1))
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (mul_a),
    .b       (mul_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

endmodule
`default_nettype wire
